ghost_mode_ctrl: RTL and testbench
==================================

# ghost_mode_ctrl

Global ghost-behaviour scheduler: sequences the classic scatter/chase timetable and overlays the power-pellet frightened mode. One instance drives the shared `isChase`/`isScatter` inputs of all four ghost movers, plus frightened, flash and reverse indications. It owns the 60 Hz frame tick, so ghost timing and mode timing stay phase-locked.

## Interface
- TICK_DIV, 416_666: clk cycles per frame tick (25 MHz / 60).
- SCATTER_LONG, 420: frames in scatter phases 0 and 2 (7 s).
- SCATTER_SHORT, 300: frames in scatter phases 4 and 6 (5 s).
- CHASE_LEN, 1200: frames in chase phases 1, 3 and 5 (20 s).
- FRIGHT_LEN, 360: frames of frightened mode per pellet (6 s).
- FLASH_LEN, 120: final frightened frames with flash asserted.

Ports:
- clk  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level start/restart pulse.
- pause  in  1  level: freezes phase and fright timers.
- powerPellet  in  1  pulse: Pac-Man ate an energizer.
- frameTick  out  1  one-cycle 60 Hz strobe.
- isScatter  out  1  scatter mode active.
- isChase  out  1  chase mode active.
- isFrightened  out  1  frightened overlay active.
- frightFlash  out  1  frightened and in final FLASH_LEN frames.
- reverse  out  1  one-cycle pulse: ghosts must reverse direction.
- phase  out  3  current schedule phase, 0..7.

## Operation
- FSM: IDLE, RUN. Reset → IDLE. `start` in any state → RUN, phase=0, phase timer=SCATTER_LONG, fright cleared, no reverse pulse.
- Frame divider free-runs from reset in both states: counter 0..TICK_DIV-1; frameTick=1 for the one cycle after it wraps.
- Qualifying tick = frameTick & RUN & !pause.
- Phases: even=scatter, odd=chase. Durations 0:SCATTER_LONG, 1:CHASE_LEN, 2:SCATTER_LONG, 3:CHASE_LEN, 4:SCATTER_SHORT, 5:CHASE_LEN, 6:SCATTER_SHORT, 7: chase forever (timer ignored).
- Phase timer (16 b): on qualifying tick with !isFrightened and phase<7, if timer==1 advance phase, load next duration, pulse reverse; else decrement. Phase lasts exactly its duration in qualifying ticks.
- Fright: powerPellet in RUN (pause irrelevant) loads fright timer=FRIGHT_LEN, sets isFrightened, pulses reverse. Ignored in IDLE. Qualifying tick while frightened: timer==1 → clear isFrightened; else decrement. Phase timer frozen throughout.
- Outputs: isScatter = RUN & !isFrightened & even phase; isChase = RUN & !isFrightened & odd phase; frightFlash = isFrightened & timer ≤ FLASH_LEN. IDLE: all mode outputs 0.
- Simultaneous events: start beats everything. powerPellet on same edge as fright expiry → reload, stays frightened. powerPellet on same edge as phase advance (not frightened) → both happen; reverse is a single one-cycle pulse.
- FRIGHT_LEN ≥ 1, all durations ≥ 1; widths are 16 b, parameters must fit.

## Timing
- All outputs registered; update on the edge where the cause is sampled, visible the following cycle.
- Reset values: frameTick=0, isScatter=0, isChase=0, isFrightened=0, frightFlash=0, reverse=0, phase=0, state IDLE, divider=0, timers=0.
- reset_n low clears all state immediately, regardless of clk, including mid-phase or mid-fright.
- reverse is never wider than one cycle; at most one per edge.
- pause only gates timers; frameTick keeps running.

## Test plan
- Reset/idle: reset_n low then high, no start, 20 frame ticks → all mode outputs 0, phase=0, reverse never asserts, frameTick every TICK_DIV cycles.
- Full schedule (TICK_DIV=4, SCATTER_LONG=3, SCATTER_SHORT=2, CHASE_LEN=5): start → scatter 3, chase 5, scatter 3, chase 5, scatter 2, chase 5, scatter 2 ticks; phase=7 after 25 ticks, isChase held 100 more ticks; exactly 7 reverse pulses.
- Fright (FRIGHT_LEN=6, FLASH_LEN=2): pellet in phase 1 with timer=2 → isFrightened 6 qualifying ticks, flash during last 2, mode outputs 0, then isChase resumes and advances to phase 2 after 2 more ticks; 2 reverse pulses.
- Re-trigger: pellet on same edge as fright timer==1 tick → isFrightened stays 1 for 6 further ticks; pellet in IDLE → no effect.
- Pause: pause high for 10 frame ticks mid-phase and mid-fright → phase and fright timers unchanged, frameTick continues; resume with exact remaining counts.
- Async reset mid-fright between clk edges → all outputs 0 immediately; start afterwards → phase 0 scatter.

Source files
------------

// File: rtl/ghost_mode_ctrl.sv
// Global ghost-mode scheduler: scatter/chase timetable with a frightened overlay,
// driven by its own frame divider so mode and ghost timing stay phase-locked.
module ghost_mode_ctrl #(
  parameter int TICK_DIV      = 416_666,
  parameter int SCATTER_LONG  = 420,
  parameter int SCATTER_SHORT = 300,
  parameter int CHASE_LEN     = 1200,
  parameter int FRIGHT_LEN    = 360,
  parameter int FLASH_LEN     = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       powerPellet,
  output logic       frameTick,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       frightFlash,
  output logic       reverse,
  output logic [2:0] phase
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [15:0] SCATTER_LONG_T  = 16'(SCATTER_LONG);
  localparam logic [15:0] SCATTER_SHORT_T = 16'(SCATTER_SHORT);
  localparam logic [15:0] CHASE_LEN_T     = 16'(CHASE_LEN);
  localparam logic [15:0] FRIGHT_LEN_T    = 16'(FRIGHT_LEN);
  localparam logic [15:0] FLASH_LEN_T     = 16'(FLASH_LEN);

  logic [0:0]       state, stateNext;
  logic [DIV_W-1:0] divCount;
  logic [15:0]      phaseTimer, phaseTimerNext;
  logic [15:0]      frightTimer, frightTimerNext;
  logic [2:0]       phaseNext;
  logic             frightNext, reverseNext, qualTick;

  // Phase 7 is the final endless chase, so its timer value is never used.
  function automatic logic [15:0] phaseDuration(input logic [2:0] p);
    case (p)
      3'd0, 3'd2: phaseDuration = SCATTER_LONG_T;
      3'd4, 3'd6: phaseDuration = SCATTER_SHORT_T;
      3'd7:       phaseDuration = 16'd0;
      default:    phaseDuration = CHASE_LEN_T;
    endcase
  endfunction

  // NOTE: reset_n is in the sensitivity list so state clears at once, without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divCount  <= '0;
      frameTick <= 1'b0;
    end else if (divCount == DIV_LAST) begin
      divCount  <= '0;
      frameTick <= 1'b1;
    end else begin
      divCount  <= divCount + DIV_W'(1);
      frameTick <= 1'b0;
    end
  end

  assign qualTick = frameTick && (state == RUN) && !pause;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    stateNext       = state;
    phaseNext       = phase;
    phaseTimerNext  = phaseTimer;
    frightNext      = isFrightened;
    frightTimerNext = frightTimer;
    reverseNext     = 1'b0;

    if (start) begin
      stateNext       = RUN;
      phaseNext       = 3'd0;
      phaseTimerNext  = SCATTER_LONG_T;
      frightNext      = 1'b0;
      frightTimerNext = 16'd0;
    end else if (state == RUN) begin
      if (qualTick) begin
        if (isFrightened) begin
          frightTimerNext = frightTimer - 16'd1;
          if (frightTimer == 16'd1) frightNext = 1'b0;
        end else if (phase != 3'd7) begin
          if (phaseTimer == 16'd1) begin
            phaseNext      = phase + 3'd1;
            phaseTimerNext = phaseDuration(phase + 3'd1);
            reverseNext    = 1'b1;
          end else begin
            phaseTimerNext = phaseTimer - 16'd1;
          end
        end
      end
      // A pellet overrides an expiry on the same edge and merges with an advance into one reverse.
      if (powerPellet) begin
        frightNext      = 1'b1;
        frightTimerNext = FRIGHT_LEN_T;
        reverseNext     = 1'b1;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= 3'd0;
      phaseTimer   <= 16'd0;
      isFrightened <= 1'b0;
      frightTimer  <= 16'd0;
      reverse      <= 1'b0;
      isScatter    <= 1'b0;
      isChase      <= 1'b0;
      frightFlash  <= 1'b0;
    end else begin
      state        <= stateNext;
      phase        <= phaseNext;
      phaseTimer   <= phaseTimerNext;
      isFrightened <= frightNext;
      frightTimer  <= frightTimerNext;
      reverse      <= reverseNext;
      isScatter    <= (stateNext == RUN) && !frightNext && !phaseNext[0];
      isChase      <= (stateNext == RUN) && !frightNext &&  phaseNext[0];
      frightFlash  <= frightNext && (frightTimerNext <= FLASH_LEN_T);
    end
  end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl: a frame-level timetable model pushes expected mode
// outputs into a scoreboard queue; each scenario pops and compares after every frame.
module tb_ghost_mode_ctrl;

  localparam int TICK_DIV      = 4;
  localparam int SCATTER_LONG  = 3;
  localparam int SCATTER_SHORT = 2;
  localparam int CHASE_LEN     = 5;
  localparam int FRIGHT_LEN    = 6;
  localparam int FLASH_LEN     = 2;
  localparam int TICK_BOUND    = 3 * TICK_DIV;

  typedef struct packed {
    logic [2:0] phase;
    logic       scatter;
    logic       chase;
    logic       fright;
    logic       flash;
    logic       rev;
  } mode_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic powerPellet = 1'b0;
  logic frameTick, isScatter, isChase, isFrightened, frightFlash, reverse;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;
  int revCount = 0;
  int revWide = 0;
  logic prevRev = 1'b0;

  mode_t sbQ[$];
  mode_t obs, exp;

  // Frame-level reference: remaining frames in the current phase / frightened period.
  bit mRun, mFright;
  int mPhase, mRem, mFrem;
  int durTable [8] = '{SCATTER_LONG, CHASE_LEN, SCATTER_LONG, CHASE_LEN,
                       SCATTER_SHORT, CHASE_LEN, SCATTER_SHORT, 0};

  ghost_mode_ctrl #(
    .TICK_DIV(TICK_DIV), .SCATTER_LONG(SCATTER_LONG), .SCATTER_SHORT(SCATTER_SHORT),
    .CHASE_LEN(CHASE_LEN), .FRIGHT_LEN(FRIGHT_LEN), .FLASH_LEN(FLASH_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .powerPellet(powerPellet),
    .frameTick(frameTick), .isScatter(isScatter), .isChase(isChase),
    .isFrightened(isFrightened), .frightFlash(frightFlash), .reverse(reverse), .phase(phase)
  );

  always #5 clk = ~clk;

  // Counts reverse pulses (value held over the previous cycle) and any pulse wider than one cycle.
  always @(posedge clk) begin
    if (reverse) revCount <= revCount + 1;
    if (reverse && prevRev) revWide <= revWide + 1;
    prevRev <= reverse;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  function automatic mode_t sample();
    mode_t s;
    s.phase   = phase;
    s.scatter = isScatter;
    s.chase   = isChase;
    s.fright  = isFrightened;
    s.flash   = frightFlash;
    s.rev     = reverse;
    return s;
  endfunction

  function automatic mode_t model_out(input logic rev);
    mode_t m;
    m.phase   = 3'(mPhase);
    m.scatter = mRun && !mFright && (mPhase % 2 == 0);
    m.chase   = mRun && !mFright && (mPhase % 2 == 1);
    m.fright  = mFright;
    m.flash   = mFright && (mFrem <= FLASH_LEN);
    m.rev     = rev;
    return m;
  endfunction

  task automatic model_reset();
    mRun = 0; mFright = 0; mPhase = 0; mRem = 0; mFrem = 0;
  endtask

  task automatic model_tick(input bit pel);
    bit rev;
    rev = 0;
    if (mRun && !pause) begin
      if (mFright) begin
        mFrem--;
        if (mFrem == 0) mFright = 0;
      end else if (mPhase < 7) begin
        mRem--;
        if (mRem == 0) begin
          mPhase++;
          mRem = durTable[mPhase];
          rev  = 1;
        end
      end
    end
    if (mRun && pel) begin
      mFright = 1; mFrem = FRIGHT_LEN; rev = 1;
    end
    sbQ.push_back(model_out(rev));
  endtask

  // Waits for the next frame tick, optionally with a pellet on the same edge; ends at the sample point.
  task automatic drive_tick(input bit pel);
    int n;
    n = 0;
    model_tick(pel);
    while (!frameTick && n < TICK_BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!frameTick) begin
      checks++; errors++;
      $display("FAIL tick_timeout: frameTick=%b after %0d cycles, want 1", frameTick, n);
    end
    powerPellet = pel;
    @(negedge clk);
    powerPellet = 1'b0;
  endtask

  // Pellet on an edge with no frame tick (callers invoke this right after drive_tick).
  task automatic drive_pellet();
    bit rev;
    rev = 0;
    if (mRun) begin
      mFright = 1; mFrem = FRIGHT_LEN; rev = 1;
    end
    sbQ.push_back(model_out(rev));
    powerPellet = 1'b1;
    @(negedge clk);
    powerPellet = 1'b0;
  endtask

  task automatic drive_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mRun = 1; mPhase = 0; mRem = SCATTER_LONG; mFright = 0; mFrem = 0;
    sbQ.push_back(model_out(1'b0));
  endtask

  task automatic test_reset();
    int n, r0;
    reset_n = 1'b0;
    #23;
    obs = sample(); checks++;
    if (obs !== '0 || frameTick !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got %b tick=%b want all 0", obs, frameTick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    r0 = revCount;
    n = 0;
    while (!frameTick && n < TICK_BOUND) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frameTick && n < TICK_BOUND);
      checks++;
      if (n != TICK_DIV) begin
        errors++;
        $display("FAIL idle_tick_period%0d: got %0d cycles want %0d", i, n, TICK_DIV);
      end
      obs = sample(); checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL idle_outputs%0d: got %b want 0", i, obs);
      end
    end
    powerPellet = 1'b1;
    @(negedge clk);
    powerPellet = 1'b0;
    @(negedge clk);
    obs = sample(); checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL idle_pellet: got %b want 0", obs);
    end
    @(negedge clk);
    checks++;
    if (revCount != r0) begin
      errors++;
      $display("FAIL idle_reverse: got %0d pulses want 0", revCount - r0);
    end
  endtask

  task automatic test_schedule();
    int r0;
    r0 = revCount;
    drive_start();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sched_start: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 125; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sched_tick%0d: got %b want %b", i, obs, exp);
      end
      if (i == 25) begin
        checks++;
        if (phase !== 3'd7 || isChase !== 1'b1) begin
          errors++;
          $display("FAIL sched_final_phase: got phase=%0d chase=%b want 7/1", phase, isChase);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (revCount - r0 != 7 || revWide != 0) begin
      errors++;
      $display("FAIL sched_reverse: got %0d pulses (%0d wide) want 7 (0)", revCount - r0, revWide);
    end
  endtask

  task automatic test_fright();
    int r0;
    drive_start();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL fright_start: got %b want %b", obs, exp);
    end
    // Three scatter frames plus three chase frames leave the chase timer at 2.
    for (int i = 0; i < 6; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fright_lead%0d: got %b want %b", i, obs, exp);
      end
    end
    r0 = revCount;
    drive_pellet();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL fright_pellet: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 8; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fright_tick%0d: got %b want %b", i, obs, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (revCount - r0 != 2 || phase !== 3'd2) begin
      errors++;
      $display("FAIL fright_reverse: got %0d pulses phase=%0d want 2 pulses phase=2", revCount - r0, phase);
    end
  endtask

  task automatic test_retrigger();
    drive_pellet();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL retrig_pellet: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 5; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL retrig_pre%0d: got %b want %b", i, obs, exp);
      end
    end
    drive_tick(1'b1);
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL retrig_edge: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 6; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL retrig_post%0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_pause();
    drive_tick(1'b0);
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pause_lead: got %b want %b", obs, exp);
    end
    pause = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pause_phase%0d: got %b want %b", i, obs, exp);
      end
    end
    pause = 1'b0;
    drive_pellet();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pause_pellet: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 22; i++) begin
      pause = (i >= 3 && i <= 12);
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pause_fright%0d: got %b want %b", i, obs, exp);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_pellet();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_pellet: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 2; i++) begin
      drive_tick(1'b0);
      exp = sbQ.pop_front(); obs = sample(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL async_mid%0d: got %b want %b", i, obs, exp);
      end
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    obs = sample(); checks++;
    if (obs !== '0 || frameTick !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got %b tick=%b want all 0", obs, frameTick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    drive_start();
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_restart: got %b want %b", obs, exp);
    end
    drive_tick(1'b0);
    exp = sbQ.pop_front(); obs = sample(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_after: got %b want %b", obs, exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_schedule();
    test_fright();
    test_retrigger();
    test_pause();
    test_async_reset();
    checks++;
    if (revWide != 0) begin
      errors++;
      $display("FAIL reverse_width: got %0d wide pulses want 0", revWide);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
